// File: rtl/count_pkg.sv
// Shared constants and helpers for the BCD timekeeping counters.
// The clamp keeps parallel loads inside the legal digit range.
package count_pkg;

    localparam int UNITS_MOD = 10;
    localparam int TENS_MOD  = 6;
    localparam int UNITS_W   = 4;
    localparam int TENS_W    = 3;

    // Out-of-range load values collapse to zero rather than saturating.
    function automatic int clamp_load(input int value, input int modulus);
        return (value >= 0 && value < modulus) ? value : 0;
    endfunction

endpackage

// File: rtl/digit_counter.sv
// One modulo-MOD digit with clamped synchronous load and a combinational
// terminal count that enables the next digit on the same clock edge.
module digit_counter
    import count_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    input  logic         load,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         Tc
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Any value at or above the top count wraps to zero, which also
    // recovers an out-of-range state on the next enabled edge.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = W'(clamp_load(int'(D), MOD));
        end else if (En) begin
            q_d = (q_q >= W'(MOD - 1)) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign Tc = En & (q_q == W'(MOD - 1));

endmodule

// File: rtl/count_mod60_bcd.sv
// Two-digit BCD modulo-60 counter; the units terminal count enables the
// tens digit so instances chain on one clock without ripple carry.
module count_mod60_bcd
    import count_pkg::*;
#(
    parameter int UNITS_MOD = count_pkg::UNITS_MOD,
    parameter int TENS_MOD  = count_pkg::TENS_MOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               En,
    input  logic               load,
    input  logic [UNITS_W-1:0] Du,
    input  logic [TENS_W-1:0]  Dt,
    output logic [UNITS_W-1:0] Qu,
    output logic [TENS_W-1:0]  Qt,
    output logic               Tc
);

    logic en_t;

    digit_counter #(
        .MOD (UNITS_MOD),
        .W   (UNITS_W)
    ) u_units (
        .clk  (clk),
        .rst  (rst),
        .En   (En),
        .load (load),
        .D    (Du),
        .Q    (Qu),
        .Tc   (en_t)
    );

    digit_counter #(
        .MOD (TENS_MOD),
        .W   (TENS_W)
    ) u_tens (
        .clk  (clk),
        .rst  (rst),
        .En   (en_t),
        .load (load),
        .D    (Dt),
        .Q    (Qt),
        .Tc   (Tc)
    );

endmodule

// File: doc/count_mod60_bcd.md
# count_mod60_bcd

Synchronous two-digit BCD modulo-60 counter (00..59) for seconds/minutes timekeeping. It is the stage directly upstream of the mod-6 tens counter: a mod-10 units digit whose terminal count drives the tens digit's enable, so the tens digit counts 0..5 exactly as the existing mod-6 block does. It exposes a ripple-carry-free terminal-count output, so instances chain (seconds → minutes) on one clock.

## Interface
Parameters:
- UNITS_MOD, 10, modulus of the units digit (fixed by package constant; not overridden in normal use)
- TENS_MOD, 6, modulus of the tens digit

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous, active-high; sampled on rising clk
- En  input  1  count enable; one increment per clk edge while high
- load  input  1  synchronous parallel load of Du/Dt
- Du  input  4  units digit to load (BCD)
- Dt  input  3  tens digit to load
- Qu  output  4  units digit, 0..9
- Qt  output  3  tens digit, 0..5
- Tc  output  1  terminal count: En & (Qt==5) & (Qu==9); combinational

## Operation
- Priority per edge: rst > load > En > hold.
- rst: Qu←0, Qt←0.
- load: Qu←Du if Du≤9 else 0; Qt←Dt if Dt≤5 else 0. Each digit is clamped independently. En is ignored on a load cycle.
- En, no load:
  - Units: Qu←(Qu==9) ? 0 : Qu+1.
  - Tens increment only when Qu==9: Qt←(Qt==5) ? 0 : Qt+1.
  - 59 → 00 wraps with Tc=1 during the 59 cycle.
- En=0: hold both digits; Tc=0.
- Out-of-range states (Qu 10..15, Qt 6..7) are unreachable through any input sequence because loads are clamped. If one occurs anyway, the next enabled edge returns that digit to 0.
- Tc is a function of the registered state and En only. It is independent of load and rst inputs, so a load cycle at 59 with En=1 still shows Tc=1.

## Timing
- Reset values: Qu=0, Qt=0, Tc=0 (Tc=0 because Qu=0).
- Latency: one clk from En/load/rst sampling to new Qu/Qt; Tc has zero latency, combinational from En.
- Chaining: downstream En = upstream Tc on the same clk. Minutes then advance on the same edge on which seconds wrap 59→00.
- Tens enable: internal en_t = En & (Qu==9), combinational; no extra pipeline stage.
- Reset asserted mid-count overrides load and En on that edge; counting resumes from 00 on the first edge after rst deasserts.
- All registers update only on rising clk; no asynchronous paths.

## Structure
- Shared package `count_pkg`:
  - UNITS_MOD=10, TENS_MOD=6
  - UNITS_W=4, TENS_W=3
  - Function clamping a load value to [0, MOD-1] (out-of-range → 0).
- One sub-module, `digit_counter` (parameters MOD, W; ports clk, rst, En, load, D, Q, Tc). It implements one mod-N digit with wrap and clamped load, and has Tc = En & (Q==MOD-1).
- Top instantiates two digit_counter instances:
  - units: En = En.
  - tens: En = units Tc, with load and rst shared.
- Top Tc = tens Tc.

## Test plan
- Reset: rst=1 for 2 cycles with En=1, load=1, Du=7 → Qu=0, Qt=0 after each edge; Tc=0.
- Full wrap: from reset, En=1 for 60 cycles → counts 00,01..09,10..59,00. Tc=1 only in the cycle showing 59; Qt steps exactly at 09→10, 19→20, …, 49→50.
- Load and clamp:
  - load Du=3, Dt=4 → 43.
  - load Du=12, Dt=7 → 00.
  - load Du=9, Dt=6 → 09.
  - load with En=1 → loaded value, no increment.
- Hold and Tc gating: at 59 set En=0 for 3 cycles → stays 59 with Tc=0; raise En → Tc=1, next edge 00.
- Reset mid-operation: count to 37, assert rst together with load Du=5, Dt=2 → 00. Deassert rst with En=1 → 01 on the next edge.
- Chaining: two instances with minutes En = seconds Tc. Load seconds 58, minutes 59, En=1 → 58/59, 59/59 (both Tc=1), then 00/00 on the same edge.
